// File: rtl/mapu_pkg.sv
// Shared types and constants for the matrix APU compute block.
package mapu_pkg;

   typedef enum logic {
      MAPU_OP_ADD  = 1'b0,
      MAPU_OP_MULT = 1'b1
   } mapu_op_t;

   typedef enum logic [1:0] {
      LOAD_A  = 2'd0,
      LOAD_B  = 2'd1,
      COMPUTE = 2'd2,
      DRAIN   = 2'd3
   } mapu_state_t;

   localparam int MAPU_DATA_WIDTH = 32;
   localparam int MAPU_N          = 3;

   // Width needed to hold a full dot product of n products of two dw-bit values.
   function automatic int mapu_acc_width(input int dw, input int n);
      return 2 * dw + $clog2(n);
   endfunction

endpackage

// File: rtl/mapu_if.sv
// Stream interface between the MAPU agent and the compute block.
// The block is the slave: it accepts input elements and drives result elements.
interface mapu_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  i_vld;
   logic                  o_rdy;
   logic [DATA_WIDTH-1:0] i_dat;
   logic                  i_op;
   logic                  o_vld;
   logic                  i_rdy;
   logic [DATA_WIDTH-1:0] o_dat;
   logic                  o_ovf;

   modport slave (
      input  i_vld, i_dat, i_op, i_rdy,
      output o_rdy, o_vld, o_dat, o_ovf
   );

   modport master (
      output i_vld, i_dat, i_op, i_rdy,
      input  o_rdy, o_vld, o_dat, o_ovf
   );
endinterface

// File: rtl/mapu_elem_calc.sv
// Combinational calculation of one result element: element-wise sum for ADD,
// row-by-column dot product for MULT, with overflow flag.
module mapu_elem_calc
   import mapu_pkg::*;
#(
   parameter int DATA_WIDTH = MAPU_DATA_WIDTH,
   parameter int N          = MAPU_N
) (
   input  mapu_op_t                       op,
   input  logic [N-1:0][DATA_WIDTH-1:0]   a_row,
   input  logic [N-1:0][DATA_WIDTH-1:0]   b_col,
   input  logic [DATA_WIDTH-1:0]          a_rc,
   input  logic [DATA_WIDTH-1:0]          b_rc,
   output logic [DATA_WIDTH-1:0]          res,
   output logic                           ovf
);

   localparam int ACC_W = mapu_acc_width(DATA_WIDTH, N);
   localparam int PW    = 2 * DATA_WIDTH;

   logic [PW-1:0]         prod;
   logic [ACC_W-1:0]      acc;
   logic [DATA_WIDTH:0]   sum;

   // Dot product accumulated at full width so no partial sum can wrap.
   always_comb begin
      prod = '0;
      acc  = '0;
      for (int k = 0; k < N; k++) begin
         prod = PW'(a_row[k]) * PW'(b_col[k]);
         acc  = acc + ACC_W'(prod);
      end
      sum = {1'b0, a_rc} + {1'b0, b_rc};
      if (op == MAPU_OP_MULT) begin
         res = acc[DATA_WIDTH-1:0];
         ovf = |acc[ACC_W-1:DATA_WIDTH];
      end else begin
         res = sum[DATA_WIDTH-1:0];
         ovf = sum[DATA_WIDTH];
      end
   end

endmodule

// File: rtl/mapu_core.sv
// Matrix APU compute block: loads A then B row-major, computes one result
// element per cycle, then streams results out with backpressure.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   LOAD_A  | accept N*N elements of A; first beat captures the op
//   LOAD_B  | accept N*N elements of B
//   COMPUTE | write one result element (and ovf) per cycle
//   DRAIN   | present results on o_vld/i_rdy until all are taken
module mapu_core
   import mapu_pkg::*;
#(
   parameter int DATA_WIDTH = MAPU_DATA_WIDTH,
   parameter int N          = MAPU_N
) (
   input  logic     clk,
   input  logic     reset_n,
   mapu_if.slave    bus
);

   localparam int RW = $clog2(N);
   localparam logic [RW-1:0] LAST = RW'(N - 1);

   typedef logic [N-1:0][N-1:0][DATA_WIDTH-1:0] mat_t;

   mapu_state_t               state_q, state_d;
   mapu_op_t                  op_q, op_d;
   logic [RW-1:0]             row_q, row_d;
   logic [RW-1:0]             col_q, col_d;
   mat_t                      a_q, a_d;
   mat_t                      b_q, b_d;
   mat_t                      res_q, res_d;
   logic [N-1:0][N-1:0]       ovfb_q, ovfb_d;
   logic                      rdy_q, rdy_d;
   logic                      vld_q, vld_d;
   logic [DATA_WIDTH-1:0]     dat_q, dat_d;
   logic                      ovf_q, ovf_d;

   logic                      accept;
   logic                      last_elem;
   logic [RW-1:0]             nxt_row;
   logic [RW-1:0]             nxt_col;

   logic [N-1:0][DATA_WIDTH-1:0] b_col;
   logic [DATA_WIDTH-1:0]        calc_res;
   logic                         calc_ovf;

   for (genvar g = 0; g < N; g++) begin : g_bcol
      assign b_col[g] = b_q[g][col_q];
   end

   mapu_elem_calc #(
      .DATA_WIDTH (DATA_WIDTH),
      .N          (N)
   ) u_calc (
      .op    (op_q),
      .a_row (a_q[row_q]),
      .b_col (b_col),
      .a_rc  (a_q[row_q][col_q]),
      .b_rc  (b_q[row_q][col_q]),
      .res   (calc_res),
      .ovf   (calc_ovf)
   );

   assign accept    = bus.i_vld && rdy_q;
   assign last_elem = (row_q == LAST) && (col_q == LAST);
   assign nxt_col   = (col_q == LAST) ? '0 : col_q + 1'b1;
   assign nxt_row   = (col_q == LAST) ? ((row_q == LAST) ? '0 : row_q + 1'b1) : row_q;

   // Next-state and next-output logic; one row/col counter pair walks every phase.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      row_d   = row_q;
      col_d   = col_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      ovfb_d  = ovfb_q;
      vld_d   = vld_q;
      dat_d   = dat_q;
      ovf_d   = ovf_q;

      case (state_q)
         LOAD_A: begin
            if (accept) begin
               a_d[row_q][col_q] = bus.i_dat;
               if (row_q == '0 && col_q == '0) begin
                  op_d = mapu_op_t'(bus.i_op);
               end
               row_d = nxt_row;
               col_d = nxt_col;
               if (last_elem) state_d = LOAD_B;
            end
         end
         LOAD_B: begin
            if (accept) begin
               b_d[row_q][col_q] = bus.i_dat;
               row_d = nxt_row;
               col_d = nxt_col;
               if (last_elem) state_d = COMPUTE;
            end
         end
         COMPUTE: begin
            res_d[row_q][col_q]  = calc_res;
            ovfb_d[row_q][col_q] = calc_ovf;
            row_d = nxt_row;
            col_d = nxt_col;
            if (last_elem) state_d = DRAIN;
         end
         DRAIN: begin
            if (!vld_q) begin
               vld_d = 1'b1;
               dat_d = res_q[row_q][col_q];
               ovf_d = ovfb_q[row_q][col_q];
            end else if (bus.i_rdy) begin
               row_d = nxt_row;
               col_d = nxt_col;
               if (last_elem) begin
                  vld_d   = 1'b0;
                  state_d = LOAD_A;
               end else begin
                  dat_d = res_q[nxt_row][nxt_col];
                  ovf_d = ovfb_q[nxt_row][nxt_col];
               end
            end
         end
         default: state_d = LOAD_A;
      endcase

      rdy_d = (state_d == LOAD_A) || (state_d == LOAD_B);
   end

   // All state and registered outputs; reset discards any job in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= LOAD_A;
         op_q    <= MAPU_OP_ADD;
         row_q   <= '0;
         col_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         ovfb_q  <= '0;
         rdy_q   <= 1'b0;
         vld_q   <= 1'b0;
         dat_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         row_q   <= row_d;
         col_q   <= col_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         ovfb_q  <= ovfb_d;
         rdy_q   <= rdy_d;
         vld_q   <= vld_d;
         dat_q   <= dat_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.o_rdy = rdy_q;
   assign bus.o_vld = vld_q;
   assign bus.o_dat = dat_q;
   assign bus.o_ovf = ovf_q;

endmodule

// File: tb/tb_mapu_core.sv
// Directed bench for mapu_core (N=3, DATA_WIDTH=32).
module tb_mapu_core;

   localparam int NN = 9;

   logic clk;
   logic reset_n;

   mapu_if #(.DATA_WIDTH(32)) bus ();

   mapu_core #(
      .DATA_WIDTH (32),
      .N          (3)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   logic [31:0] a_m [NN];
   logic [31:0] b_m [NN];
   logic [31:0] e_d [NN];
   logic        e_o [NN];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [31:0] d, input logic op);
      int n;
      bus.i_vld = 1'b1;
      bus.i_dat = d;
      bus.i_op  = op;
      n = 0;
      while (!bus.o_rdy && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         n_fail++;
         $display("FAIL send_timeout: o_rdy observed 0 for %0d cycles, required 1", n);
      end
      @(posedge clk);
      @(negedge clk);
      bus.i_vld = 1'b0;
   endtask

   // Sends A then B from a_m/b_m; i_op is inverted on every beat but the first
   // to show only the first A beat selects the operation.
   task automatic run_job(input string name, input logic op, input bit gaps, input int stall_idx);
      int lat;
      int n;
      for (int i = 0; i < 2 * NN; i++) begin
         if (gaps) begin
            bus.i_vld = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         send((i < NN) ? a_m[i] : b_m[i - NN], (i == 0) ? op : ~op);
      end
      lat = 0;
      while (!bus.o_vld && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check($sformatf("%s latency", name), 64'(lat), 64'd10);
      for (int j = 0; j < NN; j++) begin
         n = 0;
         while (!bus.o_vld && n < 100) begin
            @(negedge clk);
            n++;
         end
         if (n >= 100) begin
            n_fail++;
            $display("FAIL %s vld_timeout[%0d]: o_vld observed 0, required 1", name, j);
         end
         check($sformatf("%s dat[%0d]", name, j), 64'(bus.o_dat), 64'(e_d[j]));
         check($sformatf("%s ovf[%0d]", name, j), 64'(bus.o_ovf), 64'(e_o[j]));
         if (j == stall_idx) begin
            bus.i_rdy = 1'b0;
            for (int s = 0; s < 5; s++) begin
               @(negedge clk);
               check($sformatf("%s stall_vld[%0d]", name, s), 64'(bus.o_vld), 64'd1);
               check($sformatf("%s stall_dat[%0d]", name, s), 64'(bus.o_dat), 64'(e_d[j]));
               check($sformatf("%s stall_ovf[%0d]", name, s), 64'(bus.o_ovf), 64'(e_o[j]));
            end
            bus.i_rdy = 1'b1;
         end
         @(negedge clk);
      end
      check($sformatf("%s end_vld", name), 64'(bus.o_vld), 64'd0);
      check($sformatf("%s end_rdy", name), 64'(bus.o_rdy), 64'd1);
   endtask

   initial begin
      reset_n   = 1'b0;
      bus.i_vld = 1'b0;
      bus.i_dat = '0;
      bus.i_op  = 1'b0;
      bus.i_rdy = 1'b1;
      repeat (2) @(negedge clk);
      check("rst o_rdy", 64'(bus.o_rdy), 64'd0);
      check("rst o_vld", 64'(bus.o_vld), 64'd0);
      check("rst o_dat", 64'(bus.o_dat), 64'd0);
      check("rst o_ovf", 64'(bus.o_ovf), 64'd0);
      reset_n = 1'b1;
      #1;
      check("rel o_rdy_pre", 64'(bus.o_rdy), 64'd0);
      @(negedge clk);
      check("rel o_rdy_post", 64'(bus.o_rdy), 64'd1);

      // ADD: all ones plus all twos
      for (int i = 0; i < NN; i++) begin
         a_m[i] = 32'd1; b_m[i] = 32'd2; e_d[i] = 32'd3; e_o[i] = 1'b0;
      end
      run_job("add_basic", 1'b0, 1'b0, -1);

      // MULT: identity times 1..9
      for (int i = 0; i < NN; i++) begin
         a_m[i] = (i % 4 == 0) ? 32'd1 : 32'd0;
         b_m[i] = 32'(i + 1);
         e_d[i] = 32'(i + 1);
         e_o[i] = 1'b0;
      end
      run_job("mult_ident", 1'b1, 1'b0, -1);
      run_job("mult_ident_gaps", 1'b1, 1'b1, -1);

      // ADD overflow on element 0 only
      for (int i = 0; i < NN; i++) begin
         a_m[i] = 32'd0; b_m[i] = 32'd0; e_d[i] = 32'd0; e_o[i] = 1'b0;
      end
      a_m[0] = 32'hFFFF_FFFF;
      b_m[0] = 32'd1;
      e_o[0] = 1'b1;
      run_job("add_ovf", 1'b0, 1'b0, -1);

      // MULT overflow: every sum is 3*2^32
      for (int i = 0; i < NN; i++) begin
         a_m[i] = 32'h0001_0000; b_m[i] = 32'h0001_0000; e_d[i] = 32'd0; e_o[i] = 1'b1;
      end
      run_job("mult_ovf", 1'b1, 1'b0, -1);

      // ADD 1..9 plus 10..90 with input gaps and a stall on element 4
      for (int i = 0; i < NN; i++) begin
         a_m[i] = 32'(i + 1);
         b_m[i] = 32'(10 * (i + 1));
         e_d[i] = 32'(11 * (i + 1));
         e_o[i] = 1'b0;
      end
      run_job("add_bp", 1'b0, 1'b1, 4);

      // Reset after 12 beats (in LOAD_B), then a fresh job
      for (int i = 0; i < 12; i++) send(32'hDEAD_0000 + 32'(i), 1'b1);
      reset_n = 1'b0;
      #1;
      check("midrst o_vld", 64'(bus.o_vld), 64'd0);
      check("midrst o_rdy", 64'(bus.o_rdy), 64'd0);
      check("midrst o_dat", 64'(bus.o_dat), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("midrst rdy_pre", 64'(bus.o_rdy), 64'd0);
      check("midrst vld_pre", 64'(bus.o_vld), 64'd0);
      @(negedge clk);
      check("midrst rdy_post", 64'(bus.o_rdy), 64'd1);
      for (int i = 0; i < NN; i++) begin
         a_m[i] = 32'd5; b_m[i] = 32'(i); e_d[i] = 32'(i + 5); e_o[i] = 1'b0;
      end
      run_job("add_after_rst", 1'b0, 1'b0, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mapu_core.md
Name: mapu_core

Overview:
- Matrix APU compute block: the responder on the MAPU agent's input stream and the initiator on its output stream.
- Accepts two NxN unsigned matrices, one element per beat over valid/ready, plus an operation (ADD or MULT).
- Computes the result matrix and streams it out element by element with a per-element overflow flag.
- This is the DUT that the MAPU agent drives and monitors.

Parameters:
- DATA_WIDTH, 32, element width in bits (unsigned)
- N, 3, matrix dimension; matrices are NxN, minimum 2

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- i_vld  in  1  input element valid
- o_rdy  out  1  block ready to accept input element
- i_dat  in  DATA_WIDTH  input element
- i_op  in  1  operation, 0=ADD 1=MULT; sampled on first beat of A only
- o_vld  out  1  result element valid
- i_rdy  in  1  downstream ready for result element
- o_dat  out  DATA_WIDTH  result element
- o_ovf  out  1  result element overflowed; qualified by o_vld

Behaviour:
- One clock. Reset is asynchronous and active-low. All flops clear immediately on reset_n low.
- Reset values: o_rdy=0 while reset_n low, o_rdy=1 on first clk edge after release; o_vld=0, o_dat=0, o_ovf=0. State LOAD_A, counters 0, buffers 0.
- A beat is transferred on a rising edge where valid && ready on that interface.
- Input order: N*N elements of A, row-major, then N*N elements of B, row-major. There is no gap requirement, so full throughput is one beat per cycle.
- FSM states:
  - LOAD_A: o_rdy=1. Each beat writes A[idx]. The first beat also captures i_op. The last beat (idx=N*N-1) goes to LOAD_B.
  - LOAD_B: o_rdy=1. Each beat writes B[idx]. The last beat goes to COMPUTE.
  - COMPUTE: o_rdy=0. One result element per cycle, R[k] for k=0..N*N-1, written to the result buffer with its overflow bit. After k=N*N-1, go to DRAIN.
  - DRAIN: o_vld=1, presenting R[j] and ovf[j]. On handshake, j increments. After the last handshake, go to LOAD_A; o_vld=0 and o_rdy=1 in the next cycle.
- Latency: the last B beat is accepted at edge t; the first o_vld is high after edge t+N*N+1.
- i_vld is ignored while o_rdy=0. The block never overlaps jobs.
- o_dat and o_ovf must stay stable while o_vld && !i_rdy. o_vld never drops without a handshake.
- ADD: R[r][c] = A[r][c] + B[r][c]. Compute at DATA_WIDTH+1 bits; ovf is the carry; o_dat is the low DATA_WIDTH bits.
- MULT: R[r][c] = sum over k of A[r][k]*B[k][c]. Accumulate at 2*DATA_WIDTH+$clog2(N) bits; ovf = any bit above DATA_WIDTH-1 is set; o_dat is the truncated low bits.
- Index counters wrap to 0 at N*N-1.
- Reset mid-operation, in any state: partial matrices are discarded and the pending output is dropped. The block restarts in LOAD_A. No output is produced for the aborted job.
- i_rdy held low indefinitely: the block stalls in DRAIN with no timeout.

Decomposition:
- Shared package mapu_pkg:
  - mapu_op_t enum (MAPU_OP_ADD=0, MAPU_OP_MULT=1)
  - mapu_state_t enum (LOAD_A, LOAD_B, COMPUTE, DRAIN)
  - default N and DATA_WIDTH constants
  - function computing accumulator width
- One sub-module, mapu_elem_calc: combinational.
  - Inputs: op, A row r, B column c, B[r][c] / A[r][c].
  - Outputs: truncated result and ovf.
  - Instantiated once; used in COMPUTE, one element per cycle.

Test Plan:
- ADD, A all 1, B all 2, i_rdy=1 → 9 outputs of 3, o_ovf=0. First o_vld at 10 cycles after the last B beat (N=3).
- MULT, A=identity, B=1..9 row-major → outputs 1,2,...,9 in order, all o_ovf=0.
- ADD overflow, A[0]=32'hFFFF_FFFF, B[0]=1, remaining elements 0 → o_dat[0]=0 with o_ovf=1; remaining 8 outputs 0 with o_ovf=0.
- MULT overflow, A and B all 32'h0001_0000 → each sum = 3*2^32, so every o_dat=0 and o_ovf=1.
- Backpressure: i_rdy low for 5 cycles while element 4 is presented → o_vld stays 1, o_dat/o_ovf stay stable, no element lost or duplicated. Also, i_vld toggling randomly during LOAD states yields the same results as back-to-back input.
- reset_n pulsed low after 12 input beats, in LOAD_B → o_vld=0 immediately; o_rdy=1 one edge after release. A fresh ADD job then returns correct results, with no output from the aborted job.
